// File: rtl/dot_operand_loader.sv
// Byte-stream operand loader for the int8 dot-product engine: fills A then B, pulses start, captures the result.
// Optional feature macro LOADER_ZERO_PAD_EN: in_last ends a vector early and zero-fills its higher elements.

module dot_operand_loader #(
  parameter int VEC_LEN    = 32,
  parameter int DATA_W     = 8,
  parameter int RES_W      = 16,
  parameter int DONE_GUARD = VEC_LEN + 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_last,
  output logic [VEC_LEN*DATA_W-1:0] a_vec,
  output logic [VEC_LEN*DATA_W-1:0] b_vec,
  output logic                      dot_start,
  input  logic                      dot_done,
  input  logic [RES_W-1:0]          dot_result,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [RES_W-1:0]          res_data,
  output logic                      busy
);

  localparam int IDX_W   = $clog2(VEC_LEN) + 1;
  localparam int GUARD_W = $clog2(DONE_GUARD + 1);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, START, WAIT, OUT} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [GUARD_W-1:0] guard_reg, guard_next;
  logic [RES_W-1:0]   res_data_reg;
  logic               xfer;
  logic               vec_end;
  logic               capture;

  assign in_ready = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign xfer     = in_valid && in_ready;

`ifdef LOADER_ZERO_PAD_EN
  assign vec_end = (idx_reg == IDX_W'(VEC_LEN - 1)) || in_last;
`else
  assign vec_end = (idx_reg == IDX_W'(VEC_LEN - 1));
  logic unused_in_last;
  assign unused_in_last = in_last;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    guard_next = guard_reg;
    capture    = 1'b0;
    case (state_reg)
      LOAD_A, LOAD_B: begin
        if (xfer) begin
          if (vec_end) begin
            idx_next   = '0;
            state_next = (state_reg == LOAD_A) ? LOAD_B : START;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      START: begin
        guard_next = GUARD_W'(DONE_GUARD);
        state_next = WAIT;
      end
      WAIT: begin
        // A done that is still high from an earlier operation is masked until the guard runs out.
        if (guard_reg != '0) begin
          guard_next = guard_reg - GUARD_W'(1);
        end else if (dot_done) begin
          capture    = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        if (res_ready) begin
          idx_next   = '0;
          state_next = LOAD_A;
        end
      end
      default: begin
        idx_next   = '0;
        state_next = LOAD_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= LOAD_A;
      idx_reg      <= '0;
      guard_reg    <= '0;
      res_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      guard_reg <= guard_next;
      if (capture) begin
        res_data_reg <= dot_result;
      end
    end
  end

  assign dot_start = (state_reg == START);
  assign res_valid = (state_reg == OUT);
  assign res_data  = res_data_reg;
  assign busy      = !((state_reg == LOAD_A) && (idx_reg == '0));

  genvar gi;
  generate
    for (gi = 0; gi < VEC_LEN; gi++) begin : g_elem
      logic [DATA_W-1:0] a_elem_reg;
      logic [DATA_W-1:0] b_elem_reg;
      logic              hit;
      logic              clr;

      assign hit = xfer && (idx_reg == IDX_W'(gi));
`ifdef LOADER_ZERO_PAD_EN
      assign clr = xfer && in_last && (idx_reg < IDX_W'(gi));
`else
      assign clr = 1'b0;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          a_elem_reg <= '0;
          b_elem_reg <= '0;
        end else begin
          if (state_reg == LOAD_A) begin
            if (hit) begin
              a_elem_reg <= in_data;
            end else if (clr) begin
              a_elem_reg <= '0;
            end
          end
          if (state_reg == LOAD_B) begin
            if (hit) begin
              b_elem_reg <= in_data;
            end else if (clr) begin
              b_elem_reg <= '0;
            end
          end
        end
      end

      assign a_vec[gi*DATA_W +: DATA_W] = a_elem_reg;
      assign b_vec[gi*DATA_W +: DATA_W] = b_elem_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dot_operand_loader.sv
// Self-checking bench for dot_operand_loader: table-driven operations, a result scoreboard and reset/zero-pad sequences.
// The zero-pad sequence follows LOADER_ZERO_PAD_EN when it is defined.

module tb_dot_operand_loader;

  localparam int VEC_LEN    = 32;
  localparam int DATA_W     = 8;
  localparam int RES_W      = 16;
  localparam int DONE_GUARD = VEC_LEN + 2;
  localparam int ENG_LAT    = 34;
  localparam int VW         = VEC_LEN * DATA_W;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic [VW-1:0]     a_vec;
  logic [VW-1:0]     b_vec;
  logic              dot_start;
  logic [RES_W-1:0]  res_data;
  logic              res_valid;
  logic              res_ready;
  logic              busy;

  // Engine model: sticky done, high from time zero as a leftover of an older operation.
  logic              eng_done = 1'b1;
  logic [RES_W-1:0]  eng_res  = 16'hDEAD;
  int                eng_cnt  = 0;

  dot_operand_loader #(
    .VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .RES_W(RES_W), .DONE_GUARD(DONE_GUARD)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .a_vec(a_vec), .b_vec(b_vec),
    .dot_start(dot_start), .dot_done(eng_done), .dot_result(eng_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RES_W-1:0] dot_model(input logic [VW-1:0] a, input logic [VW-1:0] b);
    int s;
    s = 0;
    for (int i = 0; i < VEC_LEN; i++) begin
      s += $signed(a[i*DATA_W +: DATA_W]) * $signed(b[i*DATA_W +: DATA_W]);
    end
    return RES_W'(s);
  endfunction

  // Done stays high after finishing and drops only a few cycles after the next start.
  always @(posedge clk) begin
    if (dot_start) begin
      eng_cnt <= ENG_LAT;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        eng_done <= 1'b1;
        eng_res  <= dot_model(a_vec, b_vec);
      end else if (eng_cnt == ENG_LAT - 4) begin
        eng_done <= 1'b0;
      end
    end
  end

  typedef struct {
    logic [7:0]  a_byte;
    logic [7:0]  b_byte;
    logic [15:0] exp;
    bit          gaps;
    int          hold;
    bit          junk;
  } rec_t;

  rec_t          tbl[5];
  logic [7:0]    va[VEC_LEN];
  logic [7:0]    vb[VEC_LEN];
  logic [VW-1:0] exp_a;
  logic [VW-1:0] exp_b;
  logic [15:0]   sb_q[$];
  int            pass_cnt = 0;
  int            total_cnt = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b0;
    tick();
    rst = 1'b0;
    exp_a = '0;
    exp_b = '0;
    check({name, "_in_ready"}, in_ready, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_a_vec"}, a_vec, 0);
    check({name, "_b_vec"}, b_vec, 0);
    check({name, "_dot_start"}, dot_start, 0);
    check({name, "_res_valid"}, res_valid, 0);
    check({name, "_res_data"}, res_data, 0);
    $display("reset %s done", name);
  endtask

  task automatic send_vec(input bit is_b, input int first, input int n, input bit last_on_end, input bit gaps);
    for (int i = first; i < first + n; i++) begin
      logic [7:0] d;
      int w;
      d = is_b ? vb[i] : va[i];
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0; in_data = 8'($urandom); tick();
        end
      end
      in_valid = 1'b1; in_data = d; in_last = last_on_end && (i == first + n - 1);
      w = 0;
      while (!in_ready && w < 50) begin
        tick(); w++;
      end
      if (w == 50) check("in_ready_wait", in_ready, 1);
      tick();
      if (is_b) exp_b[i*DATA_W +: DATA_W] = d;
      else      exp_a[i*DATA_W +: DATA_W] = d;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic load_op(input bit gaps);
    send_vec(1'b0, 0, VEC_LEN, 1'b0, gaps);
    send_vec(1'b1, 0, VEC_LEN, 1'b0, gaps);
    check("start_after_last", dot_start, 1);
    check("a_vec_loaded", a_vec, exp_a);
    check("b_vec_loaded", b_vec, exp_b);
  endtask

  task automatic finish_op(input int hold, input bit junk);
    int          n;
    int          starts;
    bit          stable;
    logic [15:0] first;
    logic [15:0] exp;
    starts = 0;
    in_valid = junk; in_data = 8'($urandom); in_last = junk;
    tick();
    n = 1;
    check("start_one_cycle", dot_start, 0);
    while (!res_valid && n < 200) begin
      if (dot_start) starts++;
      in_valid = junk; in_data = 8'($urandom); in_last = junk;
      tick();
      n++;
    end
    check("result_latency", n, DONE_GUARD + 2);
    check("no_extra_start", starts, 0);
    check("a_vec_held", a_vec, exp_a);
    check("b_vec_held", b_vec, exp_b);
    first  = res_data;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      stable &= (res_data === first) && (in_ready === 1'b0) && (res_valid === 1'b1);
      in_valid = junk; in_data = 8'($urandom); in_last = junk;
      tick();
    end
    stable &= (res_data === first) && (res_valid === 1'b1);
    check("out_hold_stable", stable, 1);
    in_valid = 1'b0; in_last = 1'b0; res_ready = 1'b1;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      exp = sb_q.pop_front();
      check("res_data", res_data, exp);
      $display("result got %04h expected %04h latency %0d", res_data, exp, n);
    end
    tick();
    res_ready = 1'b0;
    check("post_out_in_ready", in_ready, 1);
    check("post_out_busy", busy, 0);
    check("post_out_res_valid", res_valid, 0);
    check("post_out_a_vec", a_vec, exp_a);
  endtask

  task automatic random_vecs();
    for (int i = 0; i < VEC_LEN; i++) begin
      va[i] = 8'($urandom);
      vb[i] = 8'($urandom);
    end
  endtask

  task automatic random_op();
    random_vecs();
    load_op(1'b1);
    sb_q.push_back(dot_model(exp_a, exp_b));
    finish_op(2, 1'b1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; res_ready = 1'b0;
    tbl[0] = '{8'h01, 8'h02, 16'h0040, 1'b0, 3,  1'b0};
    tbl[1] = '{8'hFF, 8'h01, 16'hFFE0, 1'b0, 0,  1'b0};
    tbl[2] = '{8'h7F, 8'h7F, 16'hE020, 1'b1, 20, 1'b1};
    tbl[3] = '{8'h80, 8'h80, 16'h0000, 1'b1, 1,  1'b1};
    tbl[4] = '{8'h80, 8'h7F, 16'h1000, 1'b0, 5,  1'b1};

    do_reset("power_on");

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < VEC_LEN; i++) begin
        va[i] = tbl[r].a_byte;
        vb[i] = tbl[r].b_byte;
      end
      load_op(tbl[r].gaps);
      sb_q.push_back(tbl[r].exp);
      finish_op(tbl[r].hold, tbl[r].junk);
    end

    random_op();

    random_vecs();
    send_vec(1'b0, 0, VEC_LEN, 1'b0, 1'b1);
    send_vec(1'b1, 0, 10, 1'b0, 1'b0);
    check("mid_b_busy", busy, 1);
    do_reset("mid_load_b");
    random_op();

    random_vecs();
    load_op(1'b0);
    repeat (5) tick();
    do_reset("mid_wait");
    random_op();

    random_vecs();
    send_vec(1'b0, 0, 5, 1'b1, 1'b0);
`ifdef LOADER_ZERO_PAD_EN
    for (int i = 5; i < VEC_LEN; i++) exp_a[i*DATA_W +: DATA_W] = '0;
    check("pad_a_zeroed", a_vec, exp_a);
    send_vec(1'b1, 0, VEC_LEN, 1'b0, 1'b0);
    check("pad_start_after_37", dot_start, 1);
    check("pad_b_vec", b_vec, exp_b);
`else
    send_vec(1'b0, 5, VEC_LEN - 5, 1'b0, 1'b0);
    check("nopad_still_loading", in_ready, 1);
    send_vec(1'b1, 0, 5, 1'b0, 1'b0);
    check("nopad_no_start_at_37", dot_start, 0);
    send_vec(1'b1, 5, VEC_LEN - 5, 1'b0, 1'b0);
    check("nopad_start_after_64", dot_start, 1);
    check("nopad_a_vec", a_vec, exp_a);
`endif
    sb_q.push_back(dot_model(exp_a, exp_b));
    finish_op(1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dot_operand_loader.md
Name: dot_operand_loader

Overview:
- Upstream feeder for the 32-element int8 dot-product engine.
- Takes a byte stream over a valid/ready handshake and fills operand buffer A, then operand buffer B.
- Holds both buffers stable, issues a one-cycle start to the engine, waits for its done, then captures the 16-bit result.
- Presents the result on a valid/ready output, then returns to loading.

Parameters:
- VEC_LEN, 32, elements per operand vector; counters sized $clog2(VEC_LEN)+1.
- DATA_W, 8, element width in bits.
- RES_W, 16, result width from the dot engine.
- DONE_GUARD, VEC_LEN+2, cycles after dot_start during which dot_done is ignored.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_ready  out  1  loader accepts a byte this cycle.
- in_data  in  DATA_W  input element; two's-complement, passed through unchanged.
- in_last  in  1  early end of the current vector (used only with LOADER_ZERO_PAD_EN).
- a_vec  out  VEC_LEN*DATA_W  operand A, flattened; element i at [i*DATA_W +: DATA_W].
- b_vec  out  VEC_LEN*DATA_W  operand B, same packing.
- dot_start  out  1  one-cycle start pulse to the engine.
- dot_done  in  1  engine done, level-sensitive; may be sticky.
- dot_result  in  RES_W  engine result.
- res_valid  out  1  captured result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  RES_W  captured result.
- busy  out  1  high in every state except LOAD_A with idx==0.

Behaviour:
- Reset (rst high at a clock edge, any state, including mid-load or mid-wait):
  - state=LOAD_A, idx=0, guard=0.
  - a_vec=0, b_vec=0, dot_start=0, res_valid=0, res_data=0.
  - In the cycle after reset, in_ready=1 and busy=0.
  - Any operation in flight is abandoned. A late dot_done is ignored because the guard must elapse after a new dot_start before it is honoured.
- A byte transfer occurs on a cycle with in_valid && in_ready. When in_ready=0, in_data and in_valid are ignored.
- LOAD_A:
  - in_ready=1.
  - Each transfer writes a_vec element idx and increments idx.
  - On the transfer with idx==VEC_LEN-1: idx<=0, go to LOAD_B.
- LOAD_B:
  - Same as LOAD_A, writing b_vec.
  - On the last element, go to START.
- START:
  - in_ready=0; dot_start=1 for exactly this one cycle.
  - guard<=DONE_GUARD; go to WAIT.
- WAIT:
  - in_ready=0, dot_start=0; guard decrements to 0 and saturates there.
  - When guard==0 && dot_done==1: res_data<=dot_result, res_valid<=1, go to OUT.
  - dot_done seen while guard!=0 is ignored, so a sticky done from the previous operation cannot be captured.
  - No timeout; WAIT is held indefinitely.
- OUT:
  - res_valid=1; res_data held stable.
  - On res_ready: res_valid<=0, go to LOAD_A with idx=0.
  - in_ready stays 0 throughout OUT, so the first byte of the next vector is accepted no earlier than the cycle after the result handshake.
- a_vec and b_vec change only during their own LOAD state. They stay constant from START until the next LOAD_A transfer.
- Throughput: 2*VEC_LEN transfer cycles + 1 + wait + 1 handshake per dot product.
- in_last without the macro: ignored.
- dot_result is captured verbatim, with no width conversion.

Optional Feature:
- Macro: LOADER_ZERO_PAD_EN.
- Defined:
  - A transfer with in_last=1 in LOAD_A or LOAD_B writes that element.
  - All higher-index elements of the same vector are cleared to 0 in that same cycle.
  - The state then advances exactly as if element VEC_LEN-1 had been written.
  - in_last on element VEC_LEN-1 is harmless.
- Undefined: in_last has no effect, and each vector always needs exactly VEC_LEN transfers.

Test Plan:
- Back-to-back in_valid; bytes 0x01 x32 then 0x02 x32; engine model sums products after 34 cycles with sticky done -> exactly one dot_start pulse, 1 cycle after the 64th transfer; res_data=0x0040; res_valid held until res_ready.
- Sticky done from the previous op held high from reset through a second load -> no capture before the guard expires; the second result (A=0xFF x32, B=0x01 x32, engine returns 0xFFE0) is captured correctly.
- Random in_valid gaps plus in_valid asserted during START/WAIT/OUT -> no writes outside LOAD states; a_vec/b_vec unchanged from START until the next LOAD_A transfer.
- rst asserted mid-LOAD_B (idx=10) and mid-WAIT -> next cycle in LOAD_A, all outputs at reset values; the following full operation is correct.
- res_ready held low 20 cycles in OUT -> res_data stable, in_ready=0; on res_ready the next cycle shows in_ready=1, busy=0.
- With LOADER_ZERO_PAD_EN: 5 A bytes with in_last on the 5th, then 32 B bytes -> a_vec elements 5..31 are 0; dot_start follows the 37th transfer. Without the macro, the same in_last pulse is ignored and 64 transfers are needed.
